hazard_stall_unit: RTL and testbench

- Producer side of the bypass network. Decodes the D-stage instruction and computes its destination register (A3), write enable (RWE) and result-ready time (Tnew).
- Pipelines A3/RWE/Tnew through E/M/W and drives the A3_*/RWE_* streams consumed by the forwarding unit.
- Raises a stall when a D-stage operand is needed (Tuse) before any bypass can supply it.
- Owns the mult/div busy counter and stalls HI/LO-class instructions while the multiplier/divider is busy.

---
 rtl/hazard_stall_unit_pkg.sv | 66 ++++++
 rtl/hazard_stall_unit_decode.sv | 135 +++++++++++++
 rtl/hazard_stall_unit.sv | 144 ++++++++++++++
 tb/tb_hazard_stall_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_defs (package)
//  Description : Opcode/funct encodings, instruction field positions and
//                shared constants for the hazard/stall producer logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  // Default width of Tnew/Tuse timing fields
  localparam int TW_DEFAULT = 2;

  // Instruction field bit positions
  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FN_HI    = 5;
  localparam int FN_LO    = 0;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Architectural registers with special meaning
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // A bubble writes nothing: destination is $0 with write enable low
  localparam logic [4:0] BUBBLE_A3  = REG_ZERO;
  localparam logic       BUBBLE_RWE = 1'b0;

  // True for every R-type funct that touches HI/LO or the mult/div unit
  function automatic logic is_md_funct(input logic [5:0] fn);
    return (fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) ||
           (fn == FN_MTLO) || (fn == FN_MULT) || (fn == FN_MULTU) ||
           (fn == FN_DIV)  || (fn == FN_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_unit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_decode
//  Description : Combinational producer/consumer decode of one instruction:
//                destination, write enable, result time (Tnew) and operand
//                need times (Tuse), plus mult/div classification.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_decode
  import mips_defs::*;
#(
  parameter int TW = TW_DEFAULT
) (
  input  logic [31:0]   ir,
  output logic [4:0]    a3,
  output logic          rwe,
  output logic [TW-1:0] tnew,
  output logic [TW-1:0] tuse_rs,
  output logic [TW-1:0] tuse_rt,
  output logic          use_rs,
  output logic          use_rt,
  output logic          md_class,
  output logic          md_op,
  output logic          is_div
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       writes;
  logic [4:0] dst;
  logic       unused_shamt;

  assign op           = ir[OP_HI:OP_LO];
  assign fn           = ir[FN_HI:FN_LO];
  assign rt           = ir[RT_HI:RT_LO];
  assign rd           = ir[RD_HI:RD_LO];
  assign unused_shamt = ^ir[SHAMT_HI:SHAMT_LO];

  // Per-opcode decode table; unlisted encodings read and write nothing
  always_comb begin
    writes   = 1'b0;
    dst      = REG_ZERO;
    tnew     = '0;
    tuse_rs  = '1;
    tuse_rt  = '1;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    md_class = 1'b0;
    md_op    = 1'b0;
    is_div   = 1'b0;
    case (op)
      OP_RTYPE: begin
        md_class = is_md_funct(fn);
        case (fn)
          FN_ADDU, FN_SUBU: begin
            writes  = 1'b1;
            dst     = rd;
            tnew    = TW'(1);
            use_rs  = 1'b1;
            tuse_rs = TW'(1);
            use_rt  = 1'b1;
            tuse_rt = TW'(1);
          end
          FN_JR: begin
            use_rs  = 1'b1;
            tuse_rs = TW'(0);
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            md_op   = 1'b1;
            is_div  = (fn == FN_DIV) || (fn == FN_DIVU);
            use_rs  = 1'b1;
            tuse_rs = TW'(1);
            use_rt  = 1'b1;
            tuse_rt = TW'(1);
          end
          FN_MTHI, FN_MTLO: begin
            use_rs  = 1'b1;
            tuse_rs = TW'(1);
          end
          FN_MFHI, FN_MFLO: begin
            writes = 1'b1;
            dst    = rd;
            tnew   = TW'(1);
          end
          default: ;
        endcase
      end
      OP_ORI: begin
        writes  = 1'b1;
        dst     = rt;
        tnew    = TW'(1);
        use_rs  = 1'b1;
        tuse_rs = TW'(1);
      end
      OP_LUI: begin
        writes = 1'b1;
        dst    = rt;
        tnew   = TW'(1);
      end
      OP_LW: begin
        writes  = 1'b1;
        dst     = rt;
        tnew    = TW'(2);
        use_rs  = 1'b1;
        tuse_rs = TW'(1);
      end
      OP_SW: begin
        use_rs  = 1'b1;
        tuse_rs = TW'(1);
        use_rt  = 1'b1;
        tuse_rt = TW'(2);
      end
      OP_BEQ: begin
        use_rs  = 1'b1;
        tuse_rs = TW'(0);
        use_rt  = 1'b1;
        tuse_rt = TW'(0);
      end
      OP_JAL: begin
        writes = 1'b1;
        dst    = REG_RA;
        tnew   = TW'(0);
      end
      default: ;
    endcase
  end

  // A write to $0 is architecturally discarded, so it never produces a hazard
  assign a3  = dst;
  assign rwe = writes && (dst != REG_ZERO);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_stall_unit
//  Description : Producer side of the bypass network. Tracks A3/RWE/Tnew
//                through E/M/W, raises data and mult/div stalls for the
//                D-stage instruction and owns the mult/div busy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int TW          = TW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   IR_D,
  output logic          stall,
  output logic [4:0]    A3_E,
  output logic [4:0]    A3_M,
  output logic [4:0]    A3_W,
  output logic          RWE_E,
  output logic          RWE_M,
  output logic          RWE_W,
  output logic [TW-1:0] Tnew_E,
  output logic [TW-1:0] Tnew_M,
  output logic          md_busy
);

  // Counter must hold the longer of the two busy periods
  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [4:0]    d_a3;
  logic          d_rwe;
  logic [TW-1:0] d_tnew;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic          d_use_rs;
  logic          d_use_rt;
  logic          d_md_class;
  logic          d_md_op;
  logic          d_is_div;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;

  logic          md_op_e;
  logic          is_div_e;
  logic [CW-1:0] md_count;

  logic          stall_data;
  logic          stall_md;

  hazard_decode #(
    .TW (TW)
  ) u_decode (
    .ir       (IR_D),
    .a3       (d_a3),
    .rwe      (d_rwe),
    .tnew     (d_tnew),
    .tuse_rs  (d_tuse_rs),
    .tuse_rt  (d_tuse_rt),
    .use_rs   (d_use_rs),
    .use_rt   (d_use_rt),
    .md_class (d_md_class),
    .md_op    (d_md_op),
    .is_div   (d_is_div)
  );

  assign d_rs = IR_D[RS_HI:RS_LO];
  assign d_rt = IR_D[RT_HI:RT_LO];

  // Data stall: an operand is needed before the in-flight producer can bypass it
  always_comb begin
    stall_data = 1'b0;
    if (d_use_rs && (d_rs != REG_ZERO)) begin
      if (RWE_E && (A3_E == d_rs) && (d_tuse_rs < Tnew_E)) stall_data = 1'b1;
      if (RWE_M && (A3_M == d_rs) && (d_tuse_rs < Tnew_M)) stall_data = 1'b1;
    end
    if (d_use_rt && (d_rt != REG_ZERO)) begin
      if (RWE_E && (A3_E == d_rt) && (d_tuse_rt < Tnew_E)) stall_data = 1'b1;
      if (RWE_M && (A3_M == d_rt) && (d_tuse_rt < Tnew_M)) stall_data = 1'b1;
    end
  end

  // HI/LO-class ops wait while a mult/div is in E or still counting down
  assign stall_md = d_md_class && (md_op_e || md_busy);
  assign stall    = stall_data || stall_md;
  assign md_busy  = (md_count != '0);

  // E stage: capture the D decode, or a bubble when D is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A3_E     <= BUBBLE_A3;
      RWE_E    <= BUBBLE_RWE;
      Tnew_E   <= '0;
      md_op_e  <= 1'b0;
      is_div_e <= 1'b0;
    end else if (stall) begin
      A3_E     <= BUBBLE_A3;
      RWE_E    <= BUBBLE_RWE;
      Tnew_E   <= '0;
      md_op_e  <= 1'b0;
      is_div_e <= 1'b0;
    end else begin
      A3_E     <= d_a3;
      RWE_E    <= d_rwe;
      Tnew_E   <= d_tnew;
      md_op_e  <= d_md_op;
      is_div_e <= d_is_div;
    end
  end

  // M and W stages: shift forward, Tnew saturating at zero as it advances
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A3_M   <= BUBBLE_A3;
      RWE_M  <= BUBBLE_RWE;
      Tnew_M <= '0;
      A3_W   <= BUBBLE_A3;
      RWE_W  <= BUBBLE_RWE;
    end else begin
      A3_M   <= A3_E;
      RWE_M  <= RWE_E;
      Tnew_M <= (Tnew_E == '0) ? '0 : (Tnew_E - TW'(1));
      A3_W   <= A3_M;
      RWE_W  <= RWE_M;
    end
  end

  // Busy counter: a new mult/div leaving E reloads, otherwise count down
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_count <= '0;
    end else if (md_op_e) begin
      md_count <= is_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_count != '0) begin
      md_count <= md_count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_stall_unit
//  Description : Self-checking bench for hazard_stall_unit. A history-based
//                reference model predicts every output each cycle; directed
//                instruction sequences add hand-computed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int HLEN   = 4096;

  logic        clk;
  logic        reset_n;
  logic [31:0] IR_D;
  logic        stall;
  logic [4:0]  A3_E, A3_M, A3_W;
  logic        RWE_E, RWE_M, RWE_W;
  logic [1:0]  Tnew_E, Tnew_M;
  logic        md_busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  hazard_stall_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .TW          (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .IR_D    (IR_D),
    .stall   (stall),
    .A3_E    (A3_E),
    .A3_M    (A3_M),
    .A3_W    (A3_W),
    .RWE_E   (RWE_E),
    .RWE_M   (RWE_M),
    .RWE_W   (RWE_W),
    .Tnew_E  (Tnew_E),
    .Tnew_M  (Tnew_M),
    .md_busy (md_busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each issue slot records what entered E on that clock; stage k holds the
  // slot issued k clocks ago. Mult/div busy is derived from when the last
  // mult/div was issued.
  typedef struct {
    int a3;
    bit we;
    int tnew;
    int md;   // 0 none, 1 mult, 2 div
  } ent_t;

  ent_t hist [HLEN];
  int   cyc = 0;
  int   md_last = -1000;
  int   md_last_kind = 0;

  function automatic ent_t bubble();
    ent_t e;
    e.a3 = 0; e.we = 0; e.tnew = 0; e.md = 0;
    return e;
  endfunction

  function automatic ent_t m_dec(logic [31:0] ir);
    ent_t e;
    int op, fn, rt, rd;
    e = bubble();
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    if (op == 0) begin
      if (fn == 'h21 || fn == 'h23 || fn == 'h10 || fn == 'h12) begin
        e.a3 = rd; e.tnew = 1;
      end
      if (fn == 'h18 || fn == 'h19) e.md = 1;
      if (fn == 'h1A || fn == 'h1B) e.md = 2;
    end
    else if (op == 'h0D || op == 'h0F) begin e.a3 = rt; e.tnew = 1; end
    else if (op == 'h23) begin e.a3 = rt; e.tnew = 2; end
    else if (op == 'h03) begin e.a3 = 31; e.tnew = 0; end
    e.we = (e.a3 != 0);
    return e;
  endfunction

  // Operand need times; -1 means the operand is not read
  function automatic void m_use(logic [31:0] ir, output int trs, output int trt);
    int op, fn;
    op = int'(ir[31:26]); fn = int'(ir[5:0]);
    trs = -1; trt = -1;
    if (op == 0) begin
      if (fn == 'h21 || fn == 'h23 || (fn >= 'h18 && fn <= 'h1B)) begin trs = 1; trt = 1; end
      if (fn == 'h08) trs = 0;
      if (fn == 'h11 || fn == 'h13) trs = 1;
    end
    else if (op == 'h0D || op == 'h23) trs = 1;
    else if (op == 'h2B) begin trs = 1; trt = 2; end
    else if (op == 'h04) begin trs = 0; trt = 0; end
  endfunction

  function automatic bit m_mdclass(logic [31:0] ir);
    int fn;
    fn = int'(ir[5:0]);
    return (ir[31:26] == 6'd0) && (fn == 'h10 || fn == 'h11 || fn == 'h12 ||
           fn == 'h13 || (fn >= 'h18 && fn <= 'h1B));
  endfunction

  function automatic ent_t stage(int k);
    if (cyc - k < 0) return bubble();
    return hist[(cyc - k) % HLEN];
  endfunction

  function automatic int sat_dec(int t);
    return (t > 0) ? t - 1 : 0;
  endfunction

  function automatic bit m_busy();
    int n;
    n = (md_last_kind == 2) ? DIV_N : MULT_N;
    return (cyc >= md_last + 2) && (cyc <= md_last + 1 + n);
  endfunction

  function automatic bit m_hz(int r, int t);
    ent_t e, m;
    e = stage(1); m = stage(2);
    if (t < 0 || r == 0) return 0;
    return (e.we && e.a3 == r && t < e.tnew) ||
           (m.we && m.a3 == r && t < sat_dec(m.tnew));
  endfunction

  function automatic bit m_stall(logic [31:0] ir);
    int trs, trt;
    m_use(ir, trs, trt);
    return m_hz(int'(ir[25:21]), trs) || m_hz(int'(ir[20:16]), trt) ||
           (m_mdclass(ir) && (stage(1).md != 0 || m_busy()));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < HLEN; i++) hist[i] = bubble();
    md_last = -1000;
    md_last_kind = 0;
  endtask

  initial m_clear();
  always @(negedge reset_n) m_clear();

  // Model advance on every clock while out of reset
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      ent_t e;
      e = m_stall(IR_D) ? bubble() : m_dec(IR_D);
      hist[cyc % HLEN] = e;
      if (e.md != 0) begin md_last = cyc; md_last_kind = e.md; end
      cyc++;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (check_en) begin
      ent_t e, m, w;
      e = stage(1); m = stage(2); w = stage(3);
      chk("stall",   stall,   m_stall(IR_D));
      chk("A3_E",    A3_E,    e.a3);
      chk("RWE_E",   RWE_E,   e.we);
      chk("Tnew_E",  Tnew_E,  e.tnew);
      chk("A3_M",    A3_M,    m.a3);
      chk("RWE_M",   RWE_M,   m.we);
      chk("Tnew_M",  Tnew_M,  sat_dec(m.tnew));
      chk("A3_W",    A3_W,    w.a3);
      chk("RWE_W",   RWE_W,   w.we);
      chk("md_busy", md_busy, m_busy());
    end
  end

  // ---------------- stimulus ----------------
  // Present an instruction in D and hold it until it issues; reports how
  // many cycles it stalled and how many of those saw md_busy high.
  task automatic issue(input logic [31:0] ir, output int ns, output int nb);
    bit done;
    ns = 0; nb = 0; done = 0;
    IR_D = ir;
    for (int k = 0; k < 40 && !done; k++) begin
      #2;
      if (md_busy) nb++;
      if (!stall) done = 1;
      else ns++;
      @(posedge clk); #1;
    end
    if (!done) chk("issue_timeout", ns, -1);
  endtask

  task automatic flush();
    int a, b;
    for (int i = 0; i < 4; i++) issue(32'h0, a, b);
  endtask

  int ns, nb;

  initial begin
    reset_n = 0;
    IR_D = 32'h0;
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_A3_E", A3_E, 0);
    chk("rst_busy", md_busy, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    check_en = 1;

    // lw $1 then addu $2,$1,$3: one-cycle load-use stall
    issue(32'h8C010000, ns, nb);
    IR_D = 32'h00231021; #2;
    chk("lw_A3_E", A3_E, 1);
    chk("lw_Tnew_E", Tnew_E, 2);
    chk("lw_addu_stall_now", stall, 1);
    @(posedge clk); #3;
    chk("lw_A3_M", A3_M, 1);
    chk("lw_Tnew_M", Tnew_M, 1);
    chk("lw_addu_stall_next", stall, 0);
    @(posedge clk); #1;
    flush();

    // addu $1 then beq $1,$0: 1 stall; lw $1 then beq: 2 stalls
    issue(32'h00430821, ns, nb);
    issue(32'h10200001, ns, nb);
    chk("addu_beq_stalls", ns, 1);
    flush();
    issue(32'h8C010000, ns, nb);
    issue(32'h10200001, ns, nb);
    chk("lw_beq_stalls", ns, 2);
    flush();

    // lw $1 then sw $1: store data is needed late enough
    issue(32'h8C010000, ns, nb);
    issue(32'hAC010000, ns, nb);
    chk("lw_sw_stalls", ns, 0);
    flush();

    // addu $0 never writes, never stalls a reader
    issue(32'h00220021, ns, nb);
    chk("addu0_RWE_E", RWE_E, 0);
    issue(32'h10000001, ns, nb);
    chk("addu0_beq_stalls", ns, 0);
    flush();

    // mult then mflo: 6 stalls, busy 5 of them; div then mflo: 11 / 10
    issue(32'h00220018, ns, nb);
    issue(32'h00001812, ns, nb);
    chk("mult_mflo_stalls", ns, 6);
    chk("mult_busy_cycles", nb, 5);
    flush();
    issue(32'h0022001A, ns, nb);
    issue(32'h00001812, ns, nb);
    chk("div_mflo_stalls", ns, 11);
    chk("div_busy_cycles", nb, 10);
    flush();

    // Mixed sequence exercised against the model only
    issue(32'h3C010001, ns, nb);   // lui $1
    issue(32'h34220005, ns, nb);   // ori $2,$1
    issue(32'h8C020000, ns, nb);   // lw $2
    issue(32'h00412023, ns, nb);   // subu $4,$2,$1
    chk("lw_subu_stalls", ns, 1);
    issue(32'h00220019, ns, nb);   // multu
    issue(32'h00800011, ns, nb);   // mthi $4
    issue(32'h00002810, ns, nb);   // mfhi $5
    issue(32'h0022001B, ns, nb);   // divu
    issue(32'h00000013, ns, nb);   // mtlo $0
    flush();

    // Reset while the multiplier is busy and lw $1 sits in E
    issue(32'h00220018, ns, nb);
    issue(32'h8C010000, ns, nb);
    chk("pre_rst_busy", md_busy, 1);
    chk("pre_rst_A3_E", A3_E, 1);
    IR_D = 32'h00231021;
    #1 reset_n = 0;
    #1;
    chk("mid_rst_busy", md_busy, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_A3_E", A3_E, 0);
    chk("mid_rst_RWE_E", RWE_E, 0);
    chk("mid_rst_A3_M", A3_M, 0);
    #1 reset_n = 1;
    issue(32'h00231021, ns, nb);
    chk("post_rst_stalls", ns, 0);
    flush();

    // jal then jr $31: link value is ready immediately
    issue(32'h0C000000, ns, nb);
    chk("jal_A3_E", A3_E, 31);
    chk("jal_RWE_E", RWE_E, 1);
    chk("jal_Tnew_E", Tnew_E, 0);
    issue(32'h03E00008, ns, nb);
    chk("jal_jr_stalls", ns, 0);
    flush();

    check_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
